seg7_scan_2digit: RTL and testbench

SEG7_SCAN_2DIGIT -- requirements
Module: seg7_scan_2digit

---
 rtl/seg7_scan_2digit.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_2digit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_2digit.sv
// seg7_scan_2digit: two-digit multiplexed 7-segment display driver.
//
// A prescaler divides the clock into digit slots of REFRESH_DIV cycles each.
// A two-state scan alternates the units slot (SLOT0) and the tens slot (SLOT1).
// Each slot begins with GUARD blanking cycles that suppress ghosting while the
// anodes switch. New digit values are sampled on update into a pending
// buffer. They are committed only at the SLOT1->SLOT0 frame boundary, so a
// frame never shows a mix of old and new digits.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (2 .. 2^20)
//   GUARD        anode-off cycles at the start of each slot (0 .. REFRESH_DIV-1)
//
// Optional feature (compile-time macro):
//   LEADING_ZERO_BLANK_EN  when defined, a committed tens digit of 0 is blanked
//
// Ports:
//   clock   in   single clock, rising edge
//   reset   in   synchronous, active-high reset
//   dig1    in   [3:0] tens digit value
//   dig0    in   [3:0] units digit value
//   update  in   strobe; dig1/dig0 sampled on every edge where update=1
//   seg     out  [6:0] active-low segments {g,f,e,d,c,b,a}
//   an      out  [1:0] active-low anodes, an[0] units, an[1] tens
//   frame   out  one-cycle pulse after a new digit pair is committed
//   err     out  high while either committed digit exceeds 9

module seg7_scan_2digit #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    input  logic       update,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame,
    output logic       err
);

    localparam int unsigned    CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        StSlot0,  // units digit
        StSlot1   // tens digit
    } state_e;

    // Active-low segment pattern for one digit; 10..15 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    state_e          state_q, state_d;
    logic [3:0]      pend_dig1_q, pend_dig1_d;
    logic [3:0]      pend_dig0_q, pend_dig0_d;
    logic            pend_valid_q, pend_valid_d;
    logic [3:0]      com_dig1_q, com_dig1_d;
    logic [3:0]      com_dig0_q, com_dig0_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;
    logic            frame_q, frame_d;
    logic            err_q, err_d;

    logic tick;
    logic boundary;
    logic in_guard;

    // Prescaler and scan state.
    always_comb begin
        tick      = (div_cnt_q == CntMax);
        div_cnt_d = tick ? '0 : div_cnt_q + CntW'(1);
        state_d   = state_q;
        if (tick) begin
            state_d = (state_q == StSlot0) ? StSlot1 : StSlot0;
        end
        boundary = tick && (state_q == StSlot1);
    end

    // Pending buffer and frame-boundary commit. A live update on the boundary
    // edge wins over anything pending, and leaves nothing pending behind.
    always_comb begin
        pend_dig1_d  = pend_dig1_q;
        pend_dig0_d  = pend_dig0_q;
        pend_valid_d = pend_valid_q;
        com_dig1_d   = com_dig1_q;
        com_dig0_d   = com_dig0_q;
        frame_d      = 1'b0;
        if (boundary && update) begin
            com_dig1_d   = dig1;
            com_dig0_d   = dig0;
            pend_valid_d = 1'b0;
            frame_d      = 1'b1;
        end else if (boundary && pend_valid_q) begin
            com_dig1_d   = pend_dig1_q;
            com_dig0_d   = pend_dig0_q;
            pend_valid_d = 1'b0;
            frame_d      = 1'b1;
        end else if (update) begin
            pend_dig1_d  = dig1;
            pend_dig0_d  = dig0;
            pend_valid_d = 1'b1;
        end
        // Taken from the next committed values so err moves with them.
        err_d = (com_dig1_d > 4'd9) || (com_dig0_d > 4'd9);
    end

    // Display outputs, computed from current state and registered one cycle later.
    always_comb begin
        in_guard = (32'(div_cnt_q) < GUARD);
        an_d     = 2'b11;
        seg_d    = 7'h7F;
        if (!in_guard) begin
            if (state_q == StSlot0) begin
                an_d  = 2'b10;
                seg_d = decode(com_dig0_q);
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (com_dig1_q != 4'd0) begin
                    an_d  = 2'b01;
                    seg_d = decode(com_dig1_q);
                end
`else
                an_d  = 2'b01;
                seg_d = decode(com_dig1_q);
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q    <= '0;
            state_q      <= StSlot0;
            pend_dig1_q  <= 4'd0;
            pend_dig0_q  <= 4'd0;
            pend_valid_q <= 1'b0;
            com_dig1_q   <= 4'd0;
            com_dig0_q   <= 4'd0;
            seg_q        <= 7'h7F;
            an_q         <= 2'b11;
            frame_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            state_q      <= state_d;
            pend_dig1_q  <= pend_dig1_d;
            pend_dig0_q  <= pend_dig0_d;
            pend_valid_q <= pend_valid_d;
            com_dig1_q   <= com_dig1_d;
            com_dig0_q   <= com_dig0_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
            err_q        <= err_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg7_scan_2digit.sv
// Testbench for seg7_scan_2digit with REFRESH_DIV=4, GUARD=1.
// cyc counts rising edges since reset release; inputs driven while cyc==p act
// on the edge ending cycle p, and outputs sampled with cyc==k reflect cycle k-1.
// One 8-cycle frame therefore shows up at cyc 8n+1 .. 8n+8.

module tb_seg7_scan_2digit;

    localparam int unsigned RefreshDiv = 4;
    localparam int unsigned Guard      = 1;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit Lzb = 1'b1;
`else
    localparam bit Lzb = 1'b0;
`endif
    // Tens slot appearance while committed tens digit is 0.
    localparam logic [1:0] AnT0  = Lzb ? 2'b11 : 2'b01;
    localparam logic [6:0] SegT0 = Lzb ? 7'h7F : 7'h40;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       update = 1'b0;
    logic [3:0] dig1   = 4'd0;
    logic [3:0] dig0   = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame;
    logic       err;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [1:0] an;
        logic [6:0] seg;
        logic       frame;
        logic       err;
        string      name;
    } exp_t;

    exp_t sb[$];

    seg7_scan_2digit #(
        .REFRESH_DIV(RefreshDiv),
        .GUARD      (Guard)
    ) dut (
        .clock (clock),
        .reset (reset),
        .dig1  (dig1),
        .dig0  (dig0),
        .update(update),
        .seg   (seg),
        .an    (an),
        .frame (frame),
        .err   (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: pops every expectation due at the current cycle and compares.
    exp_t e;
    always @(posedge clock) begin
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: cycle %0d never sampled, now at cycle %0d", e.name, e.cyc, cyc);
            end else if (an !== e.an || seg !== e.seg || frame !== e.frame || err !== e.err) begin
                errors++;
                $display("FAIL %s cyc %0d: got an=%b seg=%h frame=%b err=%b, want an=%b seg=%h frame=%b err=%b",
                         e.name, cyc, an, seg, frame, err, e.an, e.seg, e.frame, e.err);
            end
        end
    end

    task automatic ex(input int c, input logic [1:0] a, input logic [6:0] s,
                      input logic f, input logic er, input string nm);
        exp_t x;
        x.cyc = c; x.an = a; x.seg = s; x.frame = f; x.err = er; x.name = nm;
        sb.push_back(x);
    endtask

    // One full frame starting at cyc base; err switches to e1 on the last cycle.
    task automatic ex_frame(input int base, input logic [6:0] su, input logic [1:0] at,
                            input logic [6:0] st, input logic fr, input logic e0,
                            input logic e1, input string nm);
        ex(base, 2'b11, 7'h7F, 1'b0, e0, nm);
        for (int i = 1; i < 4; i++) ex(base + i, 2'b10, su, 1'b0, e0, nm);
        ex(base + 4, 2'b11, 7'h7F, 1'b0, e0, nm);
        for (int i = 5; i < 7; i++) ex(base + i, at, st, 1'b0, e0, nm);
        ex(base + 7, at, st, fr, e1, nm);
    endtask

    task automatic at_cyc(input int n);
        int spin;
        spin = 0;
        do begin
            @(negedge clock);
            spin++;
        end while (cyc != n && spin < 200);
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL at_cyc: stuck at cycle %0d waiting for %0d", cyc, n);
        end
    endtask

    task automatic drive(input logic [3:0] t, input logic [3:0] u, input logic up);
        dig1 = t; dig0 = u; update = up;
    endtask

    // Two reset edges, release; returns at the negedge where cyc==0.
    task automatic start_scenario(input string nm);
        @(negedge clock);
        ex(0, 2'b11, 7'h7F, 1'b0, 1'b0, nm);
        reset = 1'b1;
        update = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle scan, then one update committed at the frame boundary.
        start_scenario("reset_a");
        ex_frame(1,  7'h40, AnT0,  SegT0, 1'b1, 1'b0, 1'b0, "scan_idle");
        ex_frame(9,  7'h24, 2'b01, 7'h19, 1'b0, 1'b0, 1'b0, "commit_42");
        ex_frame(17, 7'h24, 2'b01, 7'h19, 1'b0, 1'b0, 1'b0, "hold_42");
        at_cyc(2);  drive(4'd4, 4'd2, 1'b1);
        at_cyc(3);  drive(4'd8, 4'd8, 1'b0);
        at_cyc(24);

        // Last-wins: 3/1 overwritten by 5/6 before commit.
        start_scenario("reset_b");
        ex_frame(1,  7'h40, AnT0,  SegT0, 1'b1, 1'b0, 1'b0, "lastwin_f0");
        ex_frame(9,  7'h02, 2'b01, 7'h12, 1'b0, 1'b0, 1'b0, "lastwin_56");
        at_cyc(1);  drive(4'd3, 4'd1, 1'b1);
        at_cyc(2);  drive(4'd3, 4'd1, 1'b0);
        at_cyc(4);  drive(4'd5, 4'd6, 1'b1);
        at_cyc(5);  drive(4'd5, 4'd6, 1'b0);
        at_cyc(16);

        // Live update on the boundary edge beats pending 1/1; nothing left pending.
        start_scenario("reset_c");
        ex_frame(1,  7'h40, AnT0,  SegT0, 1'b1, 1'b0, 1'b0, "direct_f0");
        ex_frame(9,  7'h10, 2'b01, 7'h78, 1'b0, 1'b0, 1'b0, "direct_79");
        at_cyc(3);  drive(4'd1, 4'd1, 1'b1);
        at_cyc(4);  drive(4'd1, 4'd1, 1'b0);
        at_cyc(7);  drive(4'd7, 4'd9, 1'b1);
        at_cyc(8);  drive(4'd0, 4'd0, 1'b0);
        at_cyc(16);

        // Out-of-range units digit shows a dash and raises err, then clears.
        start_scenario("reset_d");
        ex_frame(1,  7'h40, AnT0, SegT0, 1'b1, 1'b0, 1'b1, "err_set");
        ex_frame(9,  7'h3F, AnT0, SegT0, 1'b1, 1'b1, 1'b0, "err_dash");
        ex_frame(17, 7'h30, AnT0, SegT0, 1'b0, 1'b0, 1'b0, "err_clear");
        at_cyc(1);  drive(4'd0, 4'd12, 1'b1);
        at_cyc(2);  drive(4'd0, 4'd12, 1'b0);
        at_cyc(9);  drive(4'd0, 4'd3, 1'b1);
        at_cyc(10); drive(4'd0, 4'd3, 1'b0);
        at_cyc(24);

        // Reset mid-SLOT1 with data pending and update held: all discarded.
        start_scenario("reset_e");
        ex_frame(1, 7'h40, AnT0, SegT0, 1'b1, 1'b0, 1'b0, "midrst_f0");
        ex(9,  2'b11, 7'h7F, 1'b0, 1'b0, "midrst_guard0");
        for (int i = 10; i < 13; i++) ex(i, 2'b10, 7'h00, 1'b0, 1'b0, "midrst_units8");
        ex(13, 2'b11, 7'h7F, 1'b0, 1'b0, "midrst_guard1");
        ex(14, AnT0, SegT0, 1'b0, 1'b0, "midrst_tens0");
        at_cyc(1);  drive(4'd0, 4'd8, 1'b1);
        at_cyc(2);  drive(4'd0, 4'd8, 1'b0);
        at_cyc(11); drive(4'd2, 4'd3, 1'b1);
        at_cyc(12); drive(4'd2, 4'd3, 1'b0);
        at_cyc(14);
        ex(0, 2'b11, 7'h7F, 1'b0, 1'b0, "midrst_reset");
        ex_frame(1, 7'h40, AnT0, SegT0, 1'b0, 1'b0, 1'b0, "midrst_restart");
        reset = 1'b1;
        drive(4'd5, 4'd5, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        drive(4'd5, 4'd5, 1'b0);
        at_cyc(8);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expectations never checked, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
